// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width and the multiplier's state encoding.
package alu_pkg;

    localparam int ALU_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/seq_mult16_shift_add_if.sv
// Start/busy/done handshake plus operand and result bus of the sequential multiplier.
interface seq_mult16_shift_add_if
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] R;
    logic             zero;

    modport master (output start, A, B, input busy, done, R, zero);
    modport slave  (input start, A, B, output busy, done, R, zero);
endinterface

// File: rtl/seq_mult16_shift_add_adder.sv
// 16-bit ripple-carry adder with no carry-out; the sum wraps modulo 2^16.
module SemiAdder16bits (
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic [15:0] R
);
    logic [15:0] w_c;

    assign w_c[0] = 1'b0;

    for (genvar i = 0; i < 16; i++) begin : g_bit
        assign R[i] = A[i] ^ B[i] ^ w_c[i];
        if (i < 15) begin : g_carry
            assign w_c[i+1] = (A[i] & B[i]) | (w_c[i] & (A[i] ^ B[i]));
        end
    end
endmodule

// File: rtl/seq_mult16_shift_add.sv
// Shift-and-add multiplier: one partial-product add per cycle through the shared
// ripple adder, returning the low WIDTH bits of A*B.
//
//   state   | meaning
//   --------+-------------------------------------------------------
//   ST_IDLE | waiting for start; R/zero hold the last product
//   ST_RUN  | one multiplier bit consumed per cycle
//   ST_DONE | done pulse for one cycle, then back to idle
module seq_mult16_shift_add
    import alu_pkg::*;
#(
    parameter int WIDTH      = ALU_WIDTH,
    parameter int EARLY_EXIT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seq_mult16_shift_add_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    mul_state_t       r_state;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_R;
    logic             r_zero;

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0] w_mplier_next;
    logic             w_last;

    SemiAdder16bits u_add (
        .A (r_acc),
        .B (r_mcand),
        .R (w_sum)
    );

    assign w_acc_next    = r_mplier[0] ? w_sum : r_acc;
    assign w_mplier_next = r_mplier >> 1;
    // Early exit looks at the shifted multiplier so the final add still lands this cycle.
    assign w_last        = (r_cnt == CNT_W'(WIDTH - 1)) ||
                           ((EARLY_EXIT != 0) && (w_mplier_next == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_R      <= '0;
            r_zero   <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_mcand  <= bus.A;
                        r_mplier <= bus.B;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= w_mplier_next;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_R     <= w_acc_next;
                        r_zero  <= (w_acc_next == '0);
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.R    = r_R;
    assign bus.zero = r_zero;
endmodule

// File: tb/tb_seq_mult16_shift_add.sv
// Bench for seq_mult16_shift_add: one DUT per EARLY_EXIT setting, checked every
// cycle against a product/latency model, plus directed literal cases.
module tb_seq_mult16_shift_add;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;
    int   cyc;
    bit   chk_en;

    logic        start_v [2];
    logic [15:0] a_v     [2];
    logic [15:0] b_v     [2];
    logic [1:0]  busy_v;
    logic [1:0]  done_v;
    logic [1:0]  zero_v;
    logic [15:0] r_v     [2];

    seq_mult16_shift_add_if #(.WIDTH(16)) bus0 ();
    seq_mult16_shift_add_if #(.WIDTH(16)) bus1 ();

    seq_mult16_shift_add #(.WIDTH(16), .EARLY_EXIT(0)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );
    seq_mult16_shift_add #(.WIDTH(16), .EARLY_EXIT(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    assign bus0.start = start_v[0];
    assign bus0.A     = a_v[0];
    assign bus0.B     = b_v[0];
    assign bus1.start = start_v[1];
    assign bus1.A     = a_v[1];
    assign bus1.B     = b_v[1];
    assign busy_v     = {bus1.busy, bus0.busy};
    assign done_v     = {bus1.done, bus0.done};
    assign zero_v     = {bus1.zero, bus0.zero};
    assign r_v[0]     = bus0.R;
    assign r_v[1]     = bus1.R;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Cycles from accepted start to done: full width, or up to the top set bit of B.
    function automatic int lat(input bit ee, input logic [15:0] b);
        int msb;
        msb = -1;
        if (!ee) return 16;
        for (int i = 0; i < 16; i++) if (b[i]) msb = i;
        return (msb + 1 < 1) ? 1 : msb + 1;
    endfunction

    // Behavioural model: busy window, done time and held product per DUT.
    bit          m_busy [2];
    int          m_k    [2];
    int          m_n    [2];
    logic [15:0] m_prod [2];
    logic [15:0] m_r    [2];

    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_busy[d] <= 1'b0;
                m_k[d]    <= 0;
                m_n[d]    <= 0;
                m_prod[d] <= '0;
                m_r[d]    <= '0;
            end else if (m_busy[d]) begin
                m_k[d] <= m_k[d] + 1;
                if (m_k[d] + 1 == m_n[d]) m_r[d] <= m_prod[d];
                if (m_k[d] == m_n[d]) m_busy[d] <= 1'b0;
            end else if (start_v[d]) begin
                m_busy[d] <= 1'b1;
                m_k[d]    <= 0;
                m_n[d]    <= lat(d == 1, b_v[d]);
                m_prod[d] <= 16'((32'(a_v[d]) * 32'(b_v[d])) & 32'hFFFF);
            end
        end
    end

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d at cycle %0d: got %0h expected %0h", nm, d, cyc, act, exp);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                chk("busy", d, 32'(busy_v[d]), 32'(m_busy[d]));
                chk("done", d, 32'(done_v[d]), 32'(m_busy[d] && (m_k[d] == m_n[d])));
                chk("R",    d, 32'(r_v[d]),    32'(m_r[d]));
                chk("zero", d, 32'(zero_v[d]), 32'(m_r[d] == 16'h0));
            end
        end
    end

    // Caller is at a negedge with DUT d idle; returns at a negedge with it idle again.
    task automatic run_op(input int d, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_r, input int exp_n, input bit poke);
        int t0;
        int g;
        a_v[d] = a;
        b_v[d] = b;
        start_v[d] = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        start_v[d] = 1'b0;
        a_v[d] = 16'($urandom);
        b_v[d] = 16'($urandom);
        if (poke) begin
            @(negedge clk);
            start_v[d] = 1'b1;
            a_v[d] = 16'h0002;
            b_v[d] = 16'h0002;
            @(negedge clk);
            start_v[d] = 1'b0;
        end
        while (!done_v[d] && (cyc - t0) < 40) @(negedge clk);
        chk("done_seen", d, 32'(done_v[d]), 32'd1);
        chk("latency",   d, 32'(cyc - t0), 32'(exp_n));
        chk("R_lit",     d, 32'(r_v[d]), 32'(exp_r));
        chk("zero_lit",  d, 32'(zero_v[d]), 32'(exp_r == 16'h0));
        g = 0;
        while (busy_v[d] && g < 40) begin
            @(negedge clk);
            g++;
        end
        chk("idle", d, 32'(busy_v[d]), 32'd0);
    endtask

    task automatic rand_drive(input int d, input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            start_v[d] = ($urandom_range(0, 3) == 0);
            a_v[d] = 16'($urandom);
            b_v[d] = 16'($urandom);
            case ($urandom_range(0, 5))
                0: b_v[d] = 16'h0;
                1: a_v[d] = 16'h0;
                2: b_v[d] = 16'($urandom_range(0, 255));
                3: begin a_v[d] = 16'hFFFF; b_v[d] = 16'hFFFF; end
                default: ;
            endcase
        end
        @(negedge clk);
        start_v[d] = 1'b0;
    endtask

    initial begin
        int dn;
        n_checks = 0;
        n_pass   = 0;
        cyc      = 0;
        chk_en   = 1'b0;
        rst_n    = 1'b0;
        for (int d = 0; d < 2; d++) begin
            start_v[d] = 1'b0;
            a_v[d] = '0;
            b_v[d] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_R",    d, 32'(r_v[d]), 32'h0);
            chk("rst_zero", d, 32'(zero_v[d]), 32'd1);
        end
        @(negedge clk);

        run_op(1, 16'h0003, 16'h0005, 16'h000F, 3, 1'b0);
        run_op(0, 16'h0003, 16'h0005, 16'h000F, 16, 1'b0);
        run_op(1, 16'hFFFF, 16'hFFFF, 16'h0001, 16, 1'b0);
        run_op(0, 16'hFFFF, 16'hFFFF, 16'h0001, 16, 1'b0);
        run_op(1, 16'h0100, 16'h0100, 16'h0000, 9, 1'b0);
        run_op(0, 16'h0100, 16'h0100, 16'h0000, 16, 1'b0);
        run_op(1, 16'h1234, 16'h0000, 16'h0000, 1, 1'b0);
        run_op(0, 16'h1234, 16'h0000, 16'h0000, 16, 1'b0);
        run_op(1, 16'h0000, 16'h8000, 16'h0000, 16, 1'b0);
        run_op(0, 16'h0000, 16'h8000, 16'h0000, 16, 1'b0);
        run_op(1, 16'h0007, 16'h0009, 16'h003F, 4, 1'b1);
        run_op(1, 16'h0002, 16'h0002, 16'h0004, 2, 1'b0);
        run_op(0, 16'h0007, 16'h0009, 16'h003F, 16, 1'b1);
        run_op(0, 16'h0002, 16'h0002, 16'h0004, 16, 1'b0);

        // Abort both DUTs mid-run with an asynchronous reset.
        for (int d = 0; d < 2; d++) begin
            a_v[d] = 16'h00FF;
            b_v[d] = 16'h00FF;
            start_v[d] = 1'b1;
        end
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        start_v[1] = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("abort_busy", d, 32'(busy_v[d]), 32'd0);
            chk("abort_done", d, 32'(done_v[d]), 32'd0);
            chk("abort_R",    d, 32'(r_v[d]), 32'h0);
            chk("abort_zero", d, 32'(zero_v[d]), 32'd1);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        repeat (20) begin
            @(negedge clk);
            if (done_v != 2'b00) dn++;
        end
        chk("no_done_after_abort", 0, 32'(dn), 32'd0);
        run_op(1, 16'h0006, 16'h0007, 16'h002A, 3, 1'b0);
        run_op(0, 16'h0006, 16'h0007, 16'h002A, 16, 1'b0);

        fork
            rand_drive(0, 15000);
            rand_drive(1, 15000);
        join
        repeat (40) @(negedge clk);
        chk("drain", 0, 32'(busy_v), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
